// File: rtl/host_boot_streamer_if.sv
// Boot-load bundle between the host file reader, the streamer and the core-side bootloader.
// With BOOT_CHECKSUM_EN defined the bundle also carries boot_checksum.
interface host_boot_streamer_if;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] host_bootdata;
  logic        host_bootdata_req;
  logic        host_bootdata_ack;
  logic        host_rom_initialised;
  logic        busy;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0] boot_checksum;
`endif

  // Streamer side: produces the word stream and status.
  modport master (
    input  start, byte_in, byte_valid, host_bootdata_ack,
    output byte_ready, host_bootdata, host_bootdata_req, host_rom_initialised, busy
`ifdef BOOT_CHECKSUM_EN
    , output boot_checksum
`endif
  );

  // Environment side: host reader plus core bootloader.
  modport slave (
    output start, byte_in, byte_valid, host_bootdata_ack,
    input  byte_ready, host_bootdata, host_bootdata_req, host_rom_initialised, busy
`ifdef BOOT_CHECKSUM_EN
    , input boot_checksum
`endif
  );
endinterface

// File: rtl/host_boot_streamer.sv
// Packs host bytes into 32-bit words and delivers them to the core with a 4-phase req/ack handshake.
// Optional macro BOOT_CHECKSUM_EN adds a running 32-bit sum of all acknowledged words.
module host_boot_streamer #(
  parameter int ROM_BYTES = 49152,
  parameter int WCNT_W    = 14
) (
  input  logic clk,
  input  logic reset,
  host_boot_streamer_if.master bs
);

  localparam logic [WCNT_W-1:0] WORDS = WCNT_W'(ROM_BYTES / 4);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    REQ,
    WAIT_ACK_LOW,
    DONE
  } state_t;

  state_t            state_q;
  logic [31:0]       data_q;
  logic [1:0]        bcnt_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              byte_ready_q;
  logic              req_q;
  logic              init_q;
  logic              busy_q;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]       csum_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      data_q       <= '0;
      bcnt_q       <= '0;
      wcnt_q       <= '0;
      byte_ready_q <= 1'b0;
      req_q        <= 1'b0;
      init_q       <= 1'b0;
      busy_q       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bs.start) begin
            state_q      <= FILL;
            bcnt_q       <= '0;
            wcnt_q       <= '0;
            init_q       <= 1'b0;
            byte_ready_q <= 1'b1;
            busy_q       <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
            csum_q       <= '0;
`endif
          end
        end
        FILL: begin
          if (bs.byte_valid && byte_ready_q) begin
            data_q <= {data_q[23:0], bs.byte_in};
            bcnt_q <= bcnt_q + 2'd1;
            // Fourth byte completes the word; stop accepting before any fifth byte.
            if (bcnt_q == 2'd3) begin
              state_q      <= REQ;
              req_q        <= 1'b1;
              byte_ready_q <= 1'b0;
            end
          end
        end
        REQ: begin
          if (bs.host_bootdata_ack) begin
            state_q <= WAIT_ACK_LOW;
            req_q   <= 1'b0;
            wcnt_q  <= wcnt_q + 1'b1;
`ifdef BOOT_CHECKSUM_EN
            csum_q  <= csum_q + data_q;
`endif
          end
        end
        WAIT_ACK_LOW: begin
          // Strict 4-phase: the next word is not offered until ack has returned low.
          if (!bs.host_bootdata_ack) begin
            if (wcnt_q == WORDS) begin
              state_q <= DONE;
              init_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q      <= FILL;
              byte_ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          byte_ready_q <= 1'b0;
          req_q        <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bs.byte_ready           = byte_ready_q;
  assign bs.host_bootdata        = data_q;
  assign bs.host_bootdata_req    = req_q;
  assign bs.host_rom_initialised = init_q;
  assign bs.busy                 = busy_q;
`ifdef BOOT_CHECKSUM_EN
  assign bs.boot_checksum        = csum_q;
`endif

endmodule

// File: tb/tb_host_boot_streamer.sv
// Directed and randomized bench for host_boot_streamer with an 8-byte image (two words).
// The reference model assembles expected words from the bytes sent and sums acknowledged words.
module tb_host_boot_streamer;
  localparam int ROM_BYTES = 8;
  localparam int NWORDS    = ROM_BYTES / 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] exp_cs = '0;

  host_boot_streamer_if bif();

  host_boot_streamer #(.ROM_BYTES(ROM_BYTES), .WCNT_W(14)) dut (
    .clk   (clk),
    .reset (reset),
    .bs    (bif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    bif.start = 1'b1;
    step();
    bif.start = 1'b0;
    exp_cs = '0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!bif.byte_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("byte_ready_timeout", 32'(bif.byte_ready), 32'd1);
    bif.byte_in    = b;
    bif.byte_valid = 1'b1;
    step();
    bif.byte_valid = 1'b0;
    bif.byte_in    = $urandom_range(0, 255);
  endtask

  // Sends one word byte by byte (random gaps when rnd) and checks the request that follows.
  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int i = 0; i < 4; i++) begin
      if (rnd) repeat ($urandom_range(0, 2)) step();
      send_byte(w[31 - 8*i -: 8]);
    end
    chk("req_after_4th", 32'(bif.host_bootdata_req), 32'd1);
    chk("word", bif.host_bootdata, w);
    chk("ready_low_in_req", 32'(bif.byte_ready), 32'd0);
  endtask

  // Acknowledges the pending word; ack held high for 'hold' cycles, then released.
  task automatic ack_word(input logic [31:0] w, input int hold, input bit last);
    bif.host_bootdata_ack = 1'b1;
    step();
    exp_cs = exp_cs + w;
    chk("req_drop_on_ack", 32'(bif.host_bootdata_req), 32'd0);
    repeat (hold - 1) step();
    chk("no_req_while_ack_high", 32'(bif.host_bootdata_req), 32'd0);
    bif.host_bootdata_ack = 1'b0;
    step();
    if (last) begin
      chk("init_at_done", 32'(bif.host_rom_initialised), 32'd1);
      chk("busy_at_done", 32'(bif.busy), 32'd0);
`ifdef BOOT_CHECKSUM_EN
      chk("checksum_at_done", bif.boot_checksum, exp_cs);
`endif
    end else begin
      chk("ready_after_ack_low", 32'(bif.byte_ready), 32'd1);
    end
  endtask

  task automatic random_load();
    logic [31:0] w;
    pulse_start();
    chk("busy_after_start", 32'(bif.busy), 32'd1);
    chk("init_cleared", 32'(bif.host_rom_initialised), 32'd0);
    for (int k = 0; k < NWORDS; k++) begin
      w = 32'd0;
      for (int i = 0; i < 4; i++) w = (w << 8) + 32'($urandom_range(0, 255));
      send_word(w, 1'b1);
      repeat ($urandom_range(0, 3)) begin
        step();
        chk("word_stable", bif.host_bootdata, w);
      end
      ack_word(w, $urandom_range(1, 3), k == NWORDS - 1);
    end
  endtask

  initial begin
    bif.start = 1'b0;
    bif.byte_in = 8'h00;
    bif.byte_valid = 1'b0;
    bif.host_bootdata_ack = 1'b0;
    do_reset();
    chk("rst_req", 32'(bif.host_bootdata_req), 32'd0);
    chk("rst_init", 32'(bif.host_rom_initialised), 32'd0);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_ready", 32'(bif.byte_ready), 32'd0);
    chk("rst_data", bif.host_bootdata, 32'd0);
`ifdef BOOT_CHECKSUM_EN
    chk("rst_checksum", bif.boot_checksum, 32'd0);
`endif

    // Two directed words with a 3-cycle ack.
    pulse_start();
    chk("fill_ready", 32'(bif.byte_ready), 32'd1);
    chk("fill_busy", 32'(bif.busy), 32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    chk("no_req_partial", 32'(bif.host_bootdata_req), 32'd0);
    send_byte(8'h44);
    chk("req_word0", 32'(bif.host_bootdata_req), 32'd1);
    chk("word0", bif.host_bootdata, 32'h11223344);
    step();
    chk("req_held", 32'(bif.host_bootdata_req), 32'd1);
    chk("ready_low_req", 32'(bif.byte_ready), 32'd0);
    ack_word(32'h11223344, 3, 1'b0);
    send_word(32'h55667788, 1'b0);
    ack_word(32'h55667788, 1, 1'b1);

    // Restart from DONE: initialised drops on the next edge.
    pulse_start();
    chk("restart_init_low", 32'(bif.host_rom_initialised), 32'd0);
    chk("restart_busy", 32'(bif.busy), 32'd1);
    send_word(32'h0BADF00D, 1'b0);
    ack_word(32'h0BADF00D, 2, 1'b0);
    send_word(32'hCAFE1234, 1'b0);
    ack_word(32'hCAFE1234, 1, 1'b1);

    // Ack already high when REQ is entered: one word taken, then stall until ack drops.
    pulse_start();
    bif.host_bootdata_ack = 1'b1;
    send_word(32'hDEADBEEF, 1'b0);
    step();
    exp_cs = exp_cs + 32'hDEADBEEF;
    chk("ack_preset_req_drop", 32'(bif.host_bootdata_req), 32'd0);
    repeat (5) step();
    chk("stall_no_req", 32'(bif.host_bootdata_req), 32'd0);
    chk("stall_no_ready", 32'(bif.byte_ready), 32'd0);
    bif.host_bootdata_ack = 1'b0;
    step();
    chk("stall_release_ready", 32'(bif.byte_ready), 32'd1);
    send_word(32'h01020304, 1'b0);
    ack_word(32'h01020304, 1, 1'b1);

    // Reset mid-word discards the partial bytes; a start while busy is ignored.
    pulse_start();
    send_byte(8'hEE);
    send_byte(8'hFF);
    do_reset();
    chk("midrst_data", bif.host_bootdata, 32'd0);
    chk("midrst_busy", 32'(bif.busy), 32'd0);
    chk("midrst_ready", 32'(bif.byte_ready), 32'd0);
    pulse_start();
    send_byte(8'hA1);
    bif.start = 1'b1;
    step();
    bif.start = 1'b0;
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    chk("post_rst_req", 32'(bif.host_bootdata_req), 32'd1);
    chk("post_rst_word", bif.host_bootdata, 32'hA1B2C3D4);
    ack_word(32'hA1B2C3D4, 1, 1'b0);
    bif.start = 1'b1;
    step();
    bif.start = 1'b0;
    chk("start_busy_ignored_ready", 32'(bif.byte_ready), 32'd1);
    send_word(32'h10203040, 1'b0);
    ack_word(32'h10203040, 2, 1'b1);

    // Randomized loads against the model.
    for (int r = 0; r < 6; r++) random_load();

    // Checksum wraps modulo 2^32.
    pulse_start();
    send_word(32'hFFFFFFFF, 1'b0);
    ack_word(32'hFFFFFFFF, 1, 1'b0);
    send_word(32'h00000002, 1'b0);
    ack_word(32'h00000002, 1, 1'b1);
`ifdef BOOT_CHECKSUM_EN
    chk("checksum_wrap", bif.boot_checksum, 32'h00000001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
